// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with write/read handshake, fill-level count,
// programmable almost-full/almost-empty thresholds and sticky error flags.
// FWFT selects between a registered read (one-cycle latency) and
// first-word-fall-through presentation of the head word.
module fifo_sync_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int FWFT       = 0,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 1
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic                       rd_en,
    input  logic                       err_clr,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       data_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] CNT_AE    = CW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_rd_acc;

    // Status decodes of the registered count and the accept qualifiers.
    always_comb begin
        w_full   = (r_count == CNT_DEPTH);
        w_empty  = (r_count == CNT_ZERO);
        w_wr_acc = wr_en && !w_full;
        w_rd_acc = rd_en && !w_empty;
    end

    // Storage write; contents are not reset, only the pointers are.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // Pointer advance; natural wrap of the log2(DEPTH)-bit pointers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // Fill level: a balanced write+read leaves the count unchanged.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count <= CNT_ZERO;
        end else begin
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags; a new error event wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented directly; forced to zero while empty so
            // the output is defined out of reset.
            always_comb begin
                if (w_empty) begin
                    data_out = {DATA_WIDTH{1'b0}};
                end else begin
                    data_out = r_mem[r_rd_ptr];
                end
                data_valid = !w_empty;
            end
        end else begin : g_reg_read
            logic [DATA_WIDTH-1:0] r_data_out;
            logic                  r_data_valid;

            // Registered read: capture the head on an accepted read, valid for one cycle.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_data_out   <= {DATA_WIDTH{1'b0}};
                    r_data_valid <= 1'b0;
                end else begin
                    r_data_valid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_data_out <= r_mem[r_rd_ptr];
                    end
                end
            end

            assign data_out   = r_data_out;
            assign data_valid = r_data_valid;
        end
    endgenerate

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= CNT_AF);
    assign almost_empty = (r_count <= CNT_AE);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Scoreboard bench for fifo_sync_flags. One instance runs in registered-read
// mode and one in FWFT mode, both fed the same stimulus. A queue-based model
// tracks the FIFO contents; read words are pushed to an expected queue and a
// monitor pops them whenever the registered-read instance presents data.
module tb_fifo_sync_flags;

    localparam int DW = 8;
    localparam int D  = 8;
    localparam int CW = 4;
    localparam int AF = D - 2;
    localparam int AE = 1;

    logic          clk     = 1'b0;
    logic          rstn    = 1'b1;
    logic          wr_en   = 1'b0;
    logic          rd_en   = 1'b0;
    logic          err_clr = 1'b0;
    logic [DW-1:0] data_in = 8'h00;

    logic [DW-1:0] d0_data_out, d1_data_out;
    logic          d0_data_valid, d1_data_valid;
    logic          d0_full, d1_full, d0_empty, d1_empty;
    logic          d0_af, d1_af, d0_ae, d1_ae;
    logic [CW-1:0] d0_count, d1_count;
    logic          d0_ovf, d1_ovf, d0_unf, d1_unf;

    fifo_sync_flags #(.DATA_WIDTH(DW), .DEPTH(D), .FWFT(0)) dut0 (
        .clk(clk), .rstn(rstn), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .err_clr(err_clr), .data_out(d0_data_out),
        .data_valid(d0_data_valid), .full(d0_full), .empty(d0_empty),
        .almost_full(d0_af), .almost_empty(d0_ae), .count(d0_count),
        .overflow(d0_ovf), .underflow(d0_unf)
    );

    fifo_sync_flags #(.DATA_WIDTH(DW), .DEPTH(D), .FWFT(1)) dut1 (
        .clk(clk), .rstn(rstn), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .err_clr(err_clr), .data_out(d1_data_out),
        .data_valid(d1_data_valid), .full(d1_full), .empty(d1_empty),
        .almost_full(d1_af), .almost_empty(d1_ae), .count(d1_count),
        .overflow(d1_ovf), .underflow(d1_unf)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: FIFO contents as a queue, flags from the fill rules.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_q[$];
    bit            m_dv  = 1'b0;
    bit            m_ovf = 1'b0;
    bit            m_unf = 1'b0;

    task automatic model_clear();
        mq.delete();
        exp_q.delete();
        m_dv  = 1'b0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    always @(posedge clk) begin
        int  n;
        bit  wa, ra;
        if (rstn) begin
            n  = mq.size();
            wa = wr_en && (n < D);
            ra = rd_en && (n > 0);
            m_dv = ra;
            if (ra) exp_q.push_back(mq.pop_front());
            if (wa) mq.push_back(data_in);
            if (wr_en && n == D) m_ovf = 1'b1;
            else if (err_clr)    m_ovf = 1'b0;
            if (rd_en && n == 0) m_unf = 1'b1;
            else if (err_clr)    m_unf = 1'b0;
        end
    end

    // Monitor: compare status every cycle and pop the scoreboard on data_valid.
    always @(negedge clk) begin
        int n;
        if (rstn) begin
            n = mq.size();
            chk("count0", int'(d0_count), n);
            chk("count1", int'(d1_count), n);
            chk("full0", int'(d0_full), int'(n == D));
            chk("empty0", int'(d0_empty), int'(n == 0));
            chk("empty1", int'(d1_empty), int'(n == 0));
            chk("afull0", int'(d0_af), int'(n >= AF));
            chk("afull1", int'(d1_af), int'(n >= AF));
            chk("aempty0", int'(d0_ae), int'(n <= AE));
            chk("ovf0", int'(d0_ovf), int'(m_ovf));
            chk("unf0", int'(d0_unf), int'(m_unf));
            chk("ovf1", int'(d1_ovf), int'(m_ovf));
            chk("unf1", int'(d1_unf), int'(m_unf));
            chk("dvalid0", int'(d0_data_valid), int'(m_dv));
            if (d0_data_valid) begin
                if (exp_q.size() == 0) begin
                    chk("data0_unexpected", 1, 0);
                end else begin
                    chk("data0", int'(d0_data_out), int'(exp_q.pop_front()));
                end
            end
            chk("dvalid1", int'(d1_data_valid), int'(n > 0));
            if (n > 0) chk("data1", int'(d1_data_out), int'(mq[0]));
        end
    end

    task automatic cyc(input bit w, input int d, input bit r, input bit c);
        @(negedge clk);
        wr_en   = w;
        data_in = DW'(d);
        rd_en   = r;
        err_clr = c;
    endtask

    task automatic reset_checks();
        chk("rst_count0", int'(d0_count), 0);
        chk("rst_empty0", int'(d0_empty), 1);
        chk("rst_full0", int'(d0_full), 0);
        chk("rst_afull0", int'(d0_af), 0);
        chk("rst_aempty0", int'(d0_ae), 1);
        chk("rst_dout0", int'(d0_data_out), 0);
        chk("rst_dvalid0", int'(d0_data_valid), 0);
        chk("rst_ovf0", int'(d0_ovf), 0);
        chk("rst_unf0", int'(d0_unf), 0);
        chk("rst_count1", int'(d1_count), 0);
        chk("rst_dout1", int'(d1_data_out), 0);
        chk("rst_dvalid1", int'(d1_data_valid), 0);
    endtask

    initial begin
        int pw, pr;
        // Power-on reset.
        #1 rstn = 1'b0;
        model_clear();
        #1 reset_checks();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        cyc(1'b0, 0, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b0);

        // Fill 0..7, then an overflowing write of 8, then clear the error.
        for (int i = 0; i < D; i++) cyc(1'b1, i, 1'b0, 1'b0);
        cyc(1'b1, 8, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b1);
        cyc(1'b0, 0, 1'b0, 1'b0);

        // Drain with one extra read to provoke underflow.
        for (int i = 0; i < D + 1; i++) cyc(1'b0, 0, 1'b1, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b1);

        // Write into an empty FIFO, observe fall-through, then pop it.
        cyc(1'b1, 8'hA5, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b1, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b0);

        // Hold four words, then 20 cycles of simultaneous write/read across wrap.
        for (int i = 0; i < 4; i++) cyc(1'b1, i, 1'b0, 1'b0);
        for (int i = 10; i < 30; i++) cyc(1'b1, i, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 0, 1'b1, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b0);

        // Randomised traffic with alternating write/read bias.
        for (int seg = 0; seg < 8; seg++) begin
            pw = (seg % 2 == 0) ? 80 : 25;
            pr = (seg % 2 == 0) ? 25 : 80;
            for (int k = 0; k < 40; k++) begin
                cyc($urandom_range(0, 99) < pw, int'($urandom_range(0, 255)),
                    $urandom_range(0, 99) < pr, $urandom_range(0, 99) < 10);
            end
        end
        for (int i = 0; i < D; i++) cyc(1'b0, 0, 1'b1, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b1);

        // Mid-operation asynchronous reset with five words stored.
        for (int i = 0; i < 5; i++) cyc(1'b1, 40 + i, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b0);
        @(negedge clk);
        #2 rstn = 1'b0;
        model_clear();
        #1 reset_checks();
        @(negedge clk);
        rstn = 1'b1;
        cyc(1'b1, 8'h77, 1'b0, 1'b0);
        cyc(1'b1, 8'h78, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b1, 1'b0);
        cyc(1'b0, 0, 1'b1, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
